cdb_arbiter_buffered: RTL and testbench

//  Parametrised CDB arbiter with per-source result buffering, valid/ready backpressure and ROB-age squash.

---
 rtl/cdb_arbiter_buffered.sv | 195 +++++++++++++++++++
 tb/tb_cdb_arbiter_buffered.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter_buffered.sv
// CDB arbiter with per-source result FIFOs, round-robin multi-port grant and
// ROB-age squash. Losing sources stall in their FIFO instead of dropping results.
module cdb_arbiter_buffered #(
  parameter int NUM_SOURCES = 4,
  parameter int CDB_PORTS   = 2,
  parameter int BUF_DEPTH   = 4,
  parameter int XLEN        = 32,
  parameter int PHYS_W      = 7,
  parameter int ROB_W       = 6,
  parameter int SRC_W       = $clog2(NUM_SOURCES)
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_SOURCES-1:0]                src_valid,
  output logic [NUM_SOURCES-1:0]                src_ready,
  input  logic [NUM_SOURCES-1:0][PHYS_W-1:0]    src_tag,
  input  logic [NUM_SOURCES-1:0][XLEN-1:0]      src_value,
  input  logic [NUM_SOURCES-1:0][ROB_W-1:0]     src_rob_tag,
  input  logic                                  flush_valid,
  input  logic [ROB_W-1:0]                      flush_rob_tag,
  input  logic [ROB_W-1:0]                      rob_head_tag,
  output logic [CDB_PORTS-1:0]                  cdb_valid,
  output logic [CDB_PORTS-1:0][PHYS_W-1:0]      cdb_tag,
  output logic [CDB_PORTS-1:0][XLEN-1:0]        cdb_value,
  output logic [CDB_PORTS-1:0][ROB_W-1:0]       cdb_rob_tag,
  output logic [CDB_PORTS-1:0][SRC_W-1:0]       cdb_src_id
);

  // Handshake: a source transfers on any edge where src_valid && src_ready;
  // src_ready comes only from the registered FIFO count, never from src_valid.

  localparam int AW = $clog2(BUF_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(BUF_DEPTH);

  logic              mem_live  [NUM_SOURCES][BUF_DEPTH];
  logic [PHYS_W-1:0] mem_tag   [NUM_SOURCES][BUF_DEPTH];
  logic [XLEN-1:0]   mem_value [NUM_SOURCES][BUF_DEPTH];
  logic [ROB_W-1:0]  mem_rob   [NUM_SOURCES][BUF_DEPTH];
  logic [AW:0]       rd_ptr    [NUM_SOURCES];
  logic [AW:0]       wr_ptr    [NUM_SOURCES];
  logic [AW:0]       count     [NUM_SOURCES];
  logic [SRC_W-1:0]  rr_ptr;

  logic [NUM_SOURCES-1:0] has_entry;
  logic [NUM_SOURCES-1:0] head_live;
  logic [PHYS_W-1:0]      head_tag   [NUM_SOURCES];
  logic [XLEN-1:0]        head_value [NUM_SOURCES];
  logic [ROB_W-1:0]       head_rob   [NUM_SOURCES];
  logic [NUM_SOURCES-1:0] push;
  logic [NUM_SOURCES-1:0] pop;

  logic [CDB_PORTS-1:0]   gnt_valid;
  logic [SRC_W-1:0]       gnt_src [CDB_PORTS];
  logic [CDB_PORTS-1:0]   send;
  logic [CDB_PORTS-1:0]   cancel_q;
  logic                   any_grant;
  logic [SRC_W-1:0]       last_src;
  logic [SRC_W-1:0]       idx;
  int                     idx_i;
  int                     nport;

  // Age is measured from the ROB head so wrapped tags compare correctly.
  function automatic logic is_younger(input logic [ROB_W-1:0] t,
                                      input logic [ROB_W-1:0] head,
                                      input logic [ROB_W-1:0] fl);
    logic [ROB_W-1:0] age_t;
    logic [ROB_W-1:0] age_f;
    age_t = t - head;
    age_f = fl - head;
    return age_t > age_f;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_SOURCES; i++) begin
      count[i]      = wr_ptr[i] - rd_ptr[i];
      src_ready[i]  = (count[i] != FULL_CNT);
      has_entry[i]  = (count[i] != '0);
      head_live[i]  = has_entry[i] && mem_live[i][rd_ptr[i][AW-1:0]];
      head_tag[i]   = mem_tag[i][rd_ptr[i][AW-1:0]];
      head_value[i] = mem_value[i][rd_ptr[i][AW-1:0]];
      head_rob[i]   = mem_rob[i][rd_ptr[i][AW-1:0]];
    end
  end

  assign push = src_valid & src_ready;

  always_comb begin
    gnt_valid = '0;
    pop       = '0;
    any_grant = 1'b0;
    last_src  = '0;
    nport     = 0;
    idx_i     = 0;
    idx       = '0;
    for (int p = 0; p < CDB_PORTS; p++) gnt_src[p] = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      idx_i = int'(rr_ptr) + k;
      if (idx_i >= NUM_SOURCES) idx_i = idx_i - NUM_SOURCES;
      idx = SRC_W'(idx_i);
      if (head_live[idx] && nport < CDB_PORTS) begin
        for (int p = 0; p < CDB_PORTS; p++) begin
          if (p == nport) begin
            gnt_valid[p] = 1'b1;
            gnt_src[p]   = idx;
          end
        end
        nport     = nport + 1;
        pop[idx]  = 1'b1;
        any_grant = 1'b1;
        last_src  = idx;
      end
    end
    // Dead heads drain one per cycle without occupying a port.
    for (int i = 0; i < NUM_SOURCES; i++) begin
      if (has_entry[i] && !head_live[i]) pop[i] = 1'b1;
    end
  end

  // A flush cancels a younger grant in place; later ports keep their slot.
  always_comb begin
    for (int p = 0; p < CDB_PORTS; p++) begin
      send[p] = gnt_valid[p] &&
                !(flush_valid && is_younger(head_rob[gnt_src[p]], rob_head_tag, flush_rob_tag));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        rd_ptr[i] <= '0;
        wr_ptr[i] <= '0;
        for (int j = 0; j < BUF_DEPTH; j++) begin
          mem_live[i][j]  <= 1'b0;
          mem_tag[i][j]   <= '0;
          mem_value[i][j] <= '0;
          mem_rob[i][j]   <= '0;
        end
      end
      rr_ptr      <= '0;
      cdb_valid   <= '0;
      cdb_tag     <= '0;
      cdb_value   <= '0;
      cdb_rob_tag <= '0;
      cdb_src_id  <= '0;
      cancel_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_SOURCES; i++) begin
        if (flush_valid) begin
          for (int j = 0; j < BUF_DEPTH; j++) begin
            if (is_younger(mem_rob[i][j], rob_head_tag, flush_rob_tag)) mem_live[i][j] <= 1'b0;
          end
        end
        // Written after the flush sweep so the incoming entry's own live bit wins.
        if (push[i]) begin
          mem_live[i][wr_ptr[i][AW-1:0]]  <= !(flush_valid &&
                                               is_younger(src_rob_tag[i], rob_head_tag, flush_rob_tag));
          mem_tag[i][wr_ptr[i][AW-1:0]]   <= src_tag[i];
          mem_value[i][wr_ptr[i][AW-1:0]] <= src_value[i];
          mem_rob[i][wr_ptr[i][AW-1:0]]   <= src_rob_tag[i];
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        end
        if (pop[i]) rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
      if (any_grant) begin
        rr_ptr <= (last_src == SRC_W'(NUM_SOURCES - 1)) ? '0 : last_src + 1'b1;
      end
      for (int p = 0; p < CDB_PORTS; p++) begin
        cdb_valid[p]   <= send[p];
        cdb_tag[p]     <= send[p] ? head_tag[gnt_src[p]]   : '0;
        cdb_value[p]   <= send[p] ? head_value[gnt_src[p]] : '0;
        cdb_rob_tag[p] <= send[p] ? head_rob[gnt_src[p]]   : '0;
        cdb_src_id[p]  <= send[p] ? gnt_src[p]             : '0;
        cancel_q[p]    <= gnt_valid[p] && !send[p];
      end
    end
  end

  for (genvar i = 0; i < NUM_SOURCES; i++) begin : g_count_chk
    assert property (@(posedge clk) disable iff (!reset_n) count[i] <= FULL_CNT);
  end

  for (genvar p = 0; p < CDB_PORTS; p++) begin : g_gnt_chk
    for (genvar q = p + 1; q < CDB_PORTS; q++) begin : g_pair
      assert property (@(posedge clk) disable iff (!reset_n)
        !(gnt_valid[p] && gnt_valid[q] && gnt_src[p] == gnt_src[q]));
    end
  end

  // Ports fill from 0 upward; the only hole allowed is a flush-cancelled slot.
  for (genvar q = 1; q < CDB_PORTS; q++) begin : g_order_chk
    assert property (@(posedge clk) disable iff (!reset_n)
      cdb_valid[q] |-> (cdb_valid[q-1] || cancel_q[q-1]));
  end

endmodule

// File: tb/tb_cdb_arbiter_buffered.sv
// Directed bench for cdb_arbiter_buffered: N=4, P=2, depth 4; one task per scenario
// with hand-computed expectations and a per-source expected-value queue.
module tb_cdb_arbiter_buffered;

  localparam int N      = 4;
  localparam int P      = 2;
  localparam int D      = 4;
  localparam int XLEN   = 32;
  localparam int PHYS_W = 7;
  localparam int ROB_W  = 6;
  localparam int SRC_W  = 2;

  logic                        clk;
  logic                        reset_n;
  logic [N-1:0]                src_valid;
  logic [N-1:0]                src_ready;
  logic [N-1:0][PHYS_W-1:0]    src_tag;
  logic [N-1:0][XLEN-1:0]      src_value;
  logic [N-1:0][ROB_W-1:0]     src_rob_tag;
  logic                        flush_valid;
  logic [ROB_W-1:0]            flush_rob_tag;
  logic [ROB_W-1:0]            rob_head_tag;
  logic [P-1:0]                cdb_valid;
  logic [P-1:0][PHYS_W-1:0]    cdb_tag;
  logic [P-1:0][XLEN-1:0]      cdb_value;
  logic [P-1:0][ROB_W-1:0]     cdb_rob_tag;
  logic [P-1:0][SRC_W-1:0]     cdb_src_id;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q [N][$];

  cdb_arbiter_buffered #(
    .NUM_SOURCES(N), .CDB_PORTS(P), .BUF_DEPTH(D),
    .XLEN(XLEN), .PHYS_W(PHYS_W), .ROB_W(ROB_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .src_valid(src_valid), .src_ready(src_ready), .src_tag(src_tag),
    .src_value(src_value), .src_rob_tag(src_rob_tag),
    .flush_valid(flush_valid), .flush_rob_tag(flush_rob_tag), .rob_head_tag(rob_head_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_rob_tag(cdb_rob_tag), .cdb_src_id(cdb_src_id)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Driver tasks
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    src_valid     = '0;
    src_tag       = '0;
    src_value     = '0;
    src_rob_tag   = '0;
    flush_valid   = 1'b0;
    flush_rob_tag = '0;
    rob_head_tag  = '0;
  endtask

  task automatic do_reset;
    reset_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < N; i++) exp_q[i].delete();
  endtask

  task automatic test_reset;
    clear_inputs();
    reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || cdb_tag !== '0 || cdb_value !== '0) begin
      errors++;
      $display("FAIL reset_cdb: valid %b value %0h, expected 0", cdb_valid, cdb_value);
    end
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    checks++;
    if (src_ready !== 4'hF) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 1111", src_ready);
    end
    checks++;
    if (cdb_valid !== 2'b00 || cdb_rob_tag !== '0 || cdb_src_id !== '0) begin
      errors++;
      $display("FAIL reset_idle: valid %b, expected 00", cdb_valid);
    end
  endtask

  task automatic test_single_push;
    do_reset();
    src_valid[1] = 1'b1; src_tag[1] = 7'd5; src_value[1] = 32'hAA; src_rob_tag[1] = 6'd3;
    tick();
    clear_inputs();
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++; $display("FAIL t1_early: valid %b expected 00", cdb_valid);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b01) begin
      errors++; $display("FAIL t1_valid: got %b expected 01", cdb_valid);
    end
    checks++;
    if (cdb_tag[0] !== 7'd5 || cdb_value[0] !== 32'hAA || cdb_rob_tag[0] !== 6'd3 || cdb_src_id[0] !== 2'd1) begin
      errors++;
      $display("FAIL t1_fields: tag %0d val %0h rob %0d src %0d expected 5 aa 3 1",
               cdb_tag[0], cdb_value[0], cdb_rob_tag[0], cdb_src_id[0]);
    end
    checks++;
    if (cdb_tag[1] !== '0 || cdb_value[1] !== '0 || cdb_rob_tag[1] !== '0 || cdb_src_id[1] !== '0) begin
      errors++; $display("FAIL t1_port1: value %0h expected all fields 0", cdb_value[1]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++; $display("FAIL t1_one_cycle: got %b expected 00", cdb_valid);
    end
  endtask

  task automatic test_fairness;
    int gcount [N];
    int seq [N];
    int s;
    int e0;
    logic [XLEN-1:0] ev;
    do_reset();
    for (int i = 0; i < N; i++) begin gcount[i] = 0; seq[i] = 0; end
    for (int c = 0; c < 122; c++) begin
      for (int i = 0; i < N; i++) begin
        src_valid[i] = (c < 102);
        src_tag[i]   = PHYS_W'(i);
        src_value[i] = {8'(i), 24'(seq[i])};
        if (src_valid[i] && src_ready[i]) begin
          exp_q[i].push_back(src_value[i]);
          seq[i]++;
        end
      end
      if (c == 1) begin
        checks++;
        if (cdb_valid !== 2'b00) begin
          errors++; $display("FAIL t2_latency: valid %b expected 00", cdb_valid);
        end
      end
      if (c >= 2 && c < 102) begin
        e0 = (c % 2 == 0) ? 0 : 2;
        checks++;
        if (cdb_valid !== 2'b11 || int'(cdb_src_id[0]) != e0 || int'(cdb_src_id[1]) != e0 + 1) begin
          errors++;
          $display("FAIL t2_pair: cycle %0d valid %b ids %0d,%0d expected 11 ids %0d,%0d",
                   c, cdb_valid, cdb_src_id[0], cdb_src_id[1], e0, e0 + 1);
        end
        for (int p = 0; p < P; p++) if (cdb_valid[p]) gcount[int'(cdb_src_id[p])]++;
      end
      for (int p = 0; p < P; p++) begin
        if (cdb_valid[p]) begin
          s = int'(cdb_src_id[p]);
          checks++;
          if (exp_q[s].size() == 0) begin
            errors++; $display("FAIL t2_sb: src %0d got %0h expected nothing", s, cdb_value[p]);
          end else begin
            ev = exp_q[s].pop_front();
            if (cdb_value[p] !== ev) begin
              errors++; $display("FAIL t2_sb: src %0d got %0h expected %0h", s, cdb_value[p], ev);
            end
          end
        end
      end
      tick();
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (gcount[i] != 50) begin
        errors++; $display("FAIL t2_count: src %0d got %0d grants expected 50", i, gcount[i]);
      end
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++; $display("FAIL t2_lost: src %0d has %0d undelivered expected 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_backpressure;
    int seq [N];
    int s;
    int got3;
    logic exp_rdy3;
    logic [XLEN-1:0] ev;
    do_reset();
    got3 = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
    for (int c = 0; c < 32; c++) begin
      if (c <= 8) begin
        exp_rdy3 = !(c == 6 || c == 8);
        checks++;
        if (src_ready[3] !== exp_rdy3) begin
          errors++; $display("FAIL t3_ready: cycle %0d got %b expected %b", c, src_ready[3], exp_rdy3);
        end
      end
      for (int i = 0; i < N; i++) begin
        src_valid[i] = (i < 3) ? (c < 12) : (seq[3] < 7);
        src_tag[i]   = PHYS_W'(i);
        src_value[i] = {8'(i + 16), 24'(seq[i])};
        if (src_valid[i] && src_ready[i]) begin
          exp_q[i].push_back(src_value[i]);
          seq[i]++;
        end
      end
      for (int p = 0; p < P; p++) begin
        if (cdb_valid[p]) begin
          s = int'(cdb_src_id[p]);
          if (s == 3) got3++;
          checks++;
          if (exp_q[s].size() == 0) begin
            errors++; $display("FAIL t3_sb: src %0d got %0h expected nothing", s, cdb_value[p]);
          end else begin
            ev = exp_q[s].pop_front();
            if (cdb_value[p] !== ev) begin
              errors++; $display("FAIL t3_sb: src %0d got %0h expected %0h", s, cdb_value[p], ev);
            end
          end
        end
      end
      tick();
    end
    checks++;
    if (got3 != 7) begin
      errors++; $display("FAIL t3_src3_count: got %0d broadcasts expected 7", got3);
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (exp_q[i].size() != 0) begin
        errors++; $display("FAIL t3_lost: src %0d has %0d undelivered expected 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_squash;
    do_reset();
    rob_head_tag = 6'd60;
    src_valid = 4'b0111;
    src_tag[0] = 7'd10; src_rob_tag[0] = 6'd62; src_value[0] = 32'h62;
    src_tag[1] = 7'd11; src_rob_tag[1] = 6'd1;  src_value[1] = 32'h01;
    src_tag[2] = 7'd12; src_rob_tag[2] = 6'd5;  src_value[2] = 32'h05;
    tick();
    src_valid = '0;
    flush_valid = 1'b1;
    flush_rob_tag = 6'd0;
    tick();
    flush_valid = 1'b0;
    checks++;
    if (cdb_valid !== 2'b01 || cdb_rob_tag[0] !== 6'd62 || cdb_tag[0] !== 7'd10 || cdb_src_id[0] !== 2'd0) begin
      errors++;
      $display("FAIL t4_keep: valid %b rob %0d tag %0d expected 01 62 10", cdb_valid, cdb_rob_tag[0], cdb_tag[0]);
    end
    checks++;
    if (cdb_rob_tag[1] !== '0 || cdb_value[1] !== '0) begin
      errors++; $display("FAIL t4_port1: rob %0d expected 0", cdb_rob_tag[1]);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (cdb_valid !== 2'b00) begin
        errors++; $display("FAIL t4_killed: cycle %0d valid %b rob %0d expected 00", c, cdb_valid, cdb_rob_tag[0]);
      end
    end
    src_valid[2] = 1'b1; src_tag[2] = 7'd13; src_rob_tag[2] = 6'd63; src_value[2] = 32'h63;
    tick();
    src_valid = '0;
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_src_id[0] !== 2'd2 || cdb_rob_tag[0] !== 6'd63 || cdb_value[0] !== 32'h63) begin
      errors++;
      $display("FAIL t4_after: valid %b src %0d rob %0d expected 01 2 63", cdb_valid, cdb_src_id[0], cdb_rob_tag[0]);
    end
  endtask

  task automatic test_flush_concurrent;
    // Older head on port 0, younger head on port 1, younger push and equal-tag entry.
    do_reset();
    src_valid = 4'b1011;
    src_tag[0] = 7'd20; src_rob_tag[0] = 6'd2;  src_value[0] = 32'h200;
    src_tag[1] = 7'd21; src_rob_tag[1] = 6'd10; src_value[1] = 32'h201;
    src_tag[3] = 7'd23; src_rob_tag[3] = 6'd5;  src_value[3] = 32'h203;
    tick();
    src_valid = 4'b0100;
    src_tag[2] = 7'd22; src_rob_tag[2] = 6'd8; src_value[2] = 32'h202;
    flush_valid = 1'b1;
    flush_rob_tag = 6'd5;
    checks++;
    if (src_ready[2] !== 1'b1) begin
      errors++; $display("FAIL t5_push_ready: got %b expected 1", src_ready[2]);
    end
    tick();
    clear_inputs();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_rob_tag[0] !== 6'd2 || cdb_value[0] !== 32'h200 || cdb_src_id[0] !== 2'd0) begin
      errors++;
      $display("FAIL t5_older: valid %b rob %0d val %0h expected 01 2 200", cdb_valid, cdb_rob_tag[0], cdb_value[0]);
    end
    checks++;
    if (cdb_value[1] !== '0 || cdb_src_id[1] !== '0) begin
      errors++; $display("FAIL t5_cancel: port1 value %0h expected 0", cdb_value[1]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_src_id[0] !== 2'd3 || cdb_rob_tag[0] !== 6'd5) begin
      errors++;
      $display("FAIL t5_equal_kept: valid %b src %0d rob %0d expected 01 3 5", cdb_valid, cdb_src_id[0], cdb_rob_tag[0]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++; $display("FAIL t5_drain: valid %b src %0d expected 00", cdb_valid, cdb_src_id[0]);
    end
    // Younger grant on port 0 leaves a hole; older grant keeps port 1.
    do_reset();
    src_valid = 4'b0011;
    src_tag[0] = 7'd30; src_rob_tag[0] = 6'd10; src_value[0] = 32'h300;
    src_tag[1] = 7'd31; src_rob_tag[1] = 6'd2;  src_value[1] = 32'h301;
    tick();
    src_valid = '0;
    flush_valid = 1'b1;
    flush_rob_tag = 6'd5;
    tick();
    clear_inputs();
    checks++;
    if (cdb_valid !== 2'b10 || cdb_src_id[1] !== 2'd1 || cdb_rob_tag[1] !== 6'd2 || cdb_value[0] !== '0) begin
      errors++;
      $display("FAIL t5_no_renumber: valid %b src1 %0d rob1 %0d expected 10 1 2", cdb_valid, cdb_src_id[1], cdb_rob_tag[1]);
    end
  endtask

  task automatic test_reset_mid_traffic;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      src_valid = 4'hF;
      for (int i = 0; i < N; i++) src_value[i] = 32'h500 + 32'(c * 4 + i);
      tick();
    end
    checks++;
    if (cdb_valid !== 2'b11) begin
      errors++; $display("FAIL t6_busy: valid %b expected 11", cdb_valid);
    end
    #3;
    reset_n = 1'b0;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || cdb_value !== '0) begin
      errors++; $display("FAIL t6_async: valid %b expected 00 immediately", cdb_valid);
    end
    clear_inputs();
    repeat (2) tick();
    reset_n = 1'b1;
    checks++;
    if (src_ready !== 4'hF) begin
      errors++; $display("FAIL t6_ready: got %b expected 1111", src_ready);
    end
    src_valid = 4'hF;
    for (int i = 0; i < N; i++) src_value[i] = 32'hE0 + 32'(i);
    tick();
    src_valid = '0;
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++; $display("FAIL t6_stale: valid %b val %0h expected 00", cdb_valid, cdb_value[0]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_src_id[0] !== 2'd0 || cdb_src_id[1] !== 2'd1 ||
        cdb_value[0] !== 32'hE0 || cdb_value[1] !== 32'hE1) begin
      errors++;
      $display("FAIL t6_first: ids %0d,%0d vals %0h,%0h expected 0,1 e0,e1",
               cdb_src_id[0], cdb_src_id[1], cdb_value[0], cdb_value[1]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_src_id[0] !== 2'd2 || cdb_src_id[1] !== 2'd3 ||
        cdb_value[0] !== 32'hE2 || cdb_value[1] !== 32'hE3) begin
      errors++;
      $display("FAIL t6_second: ids %0d,%0d vals %0h,%0h expected 2,3 e2,e3",
               cdb_src_id[0], cdb_src_id[1], cdb_value[0], cdb_value[1]);
    end
    tick();
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++; $display("FAIL t6_empty: valid %b val %0h expected 00", cdb_valid, cdb_value[0]);
    end
  endtask

  // Sequence and final report
  initial begin
    clear_inputs();
    reset_n = 1'b1;
    test_reset();
    test_single_push();
    test_fairness();
    test_backpressure();
    test_squash();
    test_flush_concurrent();
    test_reset_mid_traffic();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
